cw305_heep_prog_bridge: RTL and testbench

// - Consumes the bridge status/instruction/address registers written over USB and turns each

---
 rtl/cw305_heep_prog_bridge.sv | 162 ++++++++++++++++
 tb/tb_cw305_heep_prog_bridge.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cw305_heep_prog_bridge.sv
// Turns posted instruction words from the USB register block into OBI writes, one word each.
// Latency: a flag seen high in IDLE starts the action on the next cycle (REQ or LOAD_ADDR).
// Backpressure: obi_req_o is held until grant or the grant timeout, then waits for rvalid.
module cw305_heep_prog_bridge #(
    parameter int pINSTR_WIDTH = 32,
    parameter int pGNT_TIMEOUT = 255,
    parameter int pCNT_WIDTH   = 16
) (
    input  logic                    usb_clk,
    input  logic                    reset_i,
    input  logic [7:0]              I_status,
    input  logic [pINSTR_WIDTH-1:0] I_instruction,
    input  logic [pINSTR_WIDTH-1:0] I_address,
    output logic                    O_reset_new_addr_valid,
    output logic                    O_reset_instr_valid,
    output logic                    obi_req_o,
    input  logic                    obi_gnt_i,
    output logic [pINSTR_WIDTH-1:0] obi_addr_o,
    output logic                    obi_we_o,
    output logic [3:0]              obi_be_o,
    output logic [pINSTR_WIDTH-1:0] obi_wdata_o,
    input  logic                    obi_rvalid_i,
    output logic                    O_busy,
    output logic [pCNT_WIDTH-1:0]   O_word_cnt,
    output logic                    O_error
);

    // Grant timer only needs to reach pGNT_TIMEOUT-1; a zero timeout disables it entirely.
    localparam int TW = (pGNT_TIMEOUT > 1) ? $clog2(pGNT_TIMEOUT) : 1;
    localparam logic [TW-1:0] TLIM = TW'((pGNT_TIMEOUT > 0) ? pGNT_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_ADDR  = 3'd1,
        REQ        = 3'd2,
        WAIT_RSP   = 3'd3,
        CLR_INSTR  = 3'd4,
        WAIT_LOW_A = 3'd5,
        WAIT_LOW_I = 3'd6
    } state_t;

    state_t                  state;
    state_t                  state_n;
    logic [pINSTR_WIDTH-1:0] ptr;
    logic [pINSTR_WIDTH-1:0] wdata;
    logic [TW-1:0]           tcnt;
    logic [pCNT_WIDTH-1:0]   cnt;
    logic                    err;
    logic                    timeout_hit;

    logic prog_en;
    logic instr_flag;
    logic addr_flag;
    logic unused_bits;

    assign prog_en     = I_status[0];
    assign instr_flag  = I_status[1];
    assign addr_flag   = I_status[2];
    assign unused_bits = ^{I_status[7:3], I_address[1:0]};

    assign timeout_hit = (pGNT_TIMEOUT != 0) && (tcnt == TLIM);

    // State register.
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode and all control outputs; address flag wins over the instruction flag.
    always_comb begin
        state_n                = state;
        obi_req_o              = 1'b0;
        obi_we_o               = 1'b0;
        O_reset_new_addr_valid = 1'b1;
        O_reset_instr_valid    = 1'b1;
        O_busy                 = (state != IDLE);
        case (state)
            IDLE: begin
                if (prog_en) begin
                    if (addr_flag) begin
                        state_n = LOAD_ADDR;
                    end else if (instr_flag) begin
                        state_n = REQ;
                    end
                end
            end
            LOAD_ADDR: begin
                O_reset_new_addr_valid = 1'b0;
                state_n                = WAIT_LOW_A;
            end
            WAIT_LOW_A: begin
                if (!addr_flag) begin
                    state_n = IDLE;
                end
            end
            REQ: begin
                obi_req_o = 1'b1;
                obi_we_o  = 1'b1;
                if (obi_gnt_i) begin
                    state_n = WAIT_RSP;
                end else if (timeout_hit) begin
                    state_n = CLR_INSTR;
                end
            end
            WAIT_RSP: begin
                if (obi_rvalid_i) begin
                    state_n = CLR_INSTR;
                end
            end
            CLR_INSTR: begin
                O_reset_instr_valid = 1'b0;
                state_n             = WAIT_LOW_I;
            end
            WAIT_LOW_I: begin
                if (!instr_flag) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath: address pointer, captured write data, grant timer, word counter, sticky error.
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            ptr   <= '0;
            wdata <= '0;
            tcnt  <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            if (state == IDLE && state_n == REQ) begin
                wdata <= I_instruction;
                tcnt  <= '0;
            end
            if (state == LOAD_ADDR) begin
                ptr <= {I_address[pINSTR_WIDTH-1:2], 2'b00};
            end
            if (state == REQ && !obi_gnt_i) begin
                if (timeout_hit) begin
                    err <= 1'b1;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
            end
            if (state == WAIT_RSP && obi_rvalid_i) begin
                ptr <= ptr + pINSTR_WIDTH'(4);
                cnt <= cnt + pCNT_WIDTH'(1);
            end
        end
    end

    assign obi_addr_o  = ptr;
    assign obi_wdata_o = wdata;
    assign obi_be_o    = 4'hF;
    assign O_word_cnt  = cnt;
    assign O_error     = err;

endmodule

// File: tb/tb_cw305_heep_prog_bridge.sv
// Bench for the program-loading bridge: models the USB register block and an OBI slave,
// predicts every write from a simple pointer model and checks writes in a separate monitor.
module tb_cw305_heep_prog_bridge;

    logic        usb_clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [7:0]  I_status = 8'h00;
    logic [31:0] I_instruction = '0;
    logic [31:0] I_address = '0;
    logic        O_reset_new_addr_valid;
    logic        O_reset_instr_valid;
    logic        obi_req_o;
    logic        obi_gnt_i = 1'b0;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid_i = 1'b0;
    logic        O_busy;
    logic [15:0] O_word_cnt;
    logic        O_error;

    cw305_heep_prog_bridge #(
        .pINSTR_WIDTH(32),
        .pGNT_TIMEOUT(4),
        .pCNT_WIDTH  (16)
    ) dut (
        .usb_clk               (usb_clk),
        .reset_i               (reset_i),
        .I_status              (I_status),
        .I_instruction         (I_instruction),
        .I_address             (I_address),
        .O_reset_new_addr_valid(O_reset_new_addr_valid),
        .O_reset_instr_valid   (O_reset_instr_valid),
        .obi_req_o             (obi_req_o),
        .obi_gnt_i             (obi_gnt_i),
        .obi_addr_o            (obi_addr_o),
        .obi_we_o              (obi_we_o),
        .obi_be_o              (obi_be_o),
        .obi_wdata_o           (obi_wdata_o),
        .obi_rvalid_i          (obi_rvalid_i),
        .O_busy                (O_busy),
        .O_word_cnt            (O_word_cnt),
        .O_error               (O_error)
    );

    always #5 usb_clk = ~usb_clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    // Register-block flags and OBI slave knobs.
    logic st_instr = 1'b0, st_addr = 1'b0, prog_en = 1'b0;
    logic gnt_en = 1'b1, hs = 1'b0, rsp_pending = 1'b0;
    int   gnt_delay = 0, rsp_delay = 0, rsp_wait = 0, req_run = 0;
    int   hold_cycles = 0, hold_left = 0;

    // Monitor counters.
    int wr_seen = 0, req_cyc = 0, clr_i_seen = 0, clr_a_seen = 0;

    // Reference model: byte pointer and completed-word count.
    logic [31:0] m_ptr = '0;
    int          exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle of the environment: register block clears, OBI slave responds, status driven.
    task automatic tick();
        @(negedge usb_clk);
        if (!O_reset_instr_valid) begin
            if (hold_cycles > 0) hold_left = hold_cycles;
            else st_instr = 1'b0;
        end else if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) st_instr = 1'b0;
        end
        if (!O_reset_new_addr_valid) st_addr = 1'b0;
        obi_rvalid_i = 1'b0;
        if (hs) begin
            rsp_pending = 1'b1;
            rsp_wait    = rsp_delay;
            hs          = 1'b0;
        end
        if (rsp_pending) begin
            if (rsp_wait == 0) begin
                obi_rvalid_i = 1'b1;
                rsp_pending  = 1'b0;
            end else begin
                rsp_wait--;
            end
        end
        if (obi_req_o) req_run++;
        else req_run = 0;
        obi_gnt_i = !reset_i && obi_req_o && gnt_en && (req_run > gnt_delay);
        hs        = obi_gnt_i;
        I_status  = {5'b0, st_addr, st_instr, prog_en};
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 300; i++) begin
            tick();
            if (!O_busy && !st_instr && !st_addr) break;
        end
        chk({name, "_done_in_time"}, 32'(i < 300), 32'd1);
    endtask

    task automatic post_addr(input logic [31:0] a);
        I_address = a;
        st_addr   = 1'b1;
        m_ptr     = a & 32'hFFFF_FFFC;
        wait_idle("addr");
    endtask

    task automatic post_instr(input logic [31:0] d, input bit ok);
        I_instruction = d;
        st_instr      = 1'b1;
        if (ok) begin
            sb.push_back('{m_ptr, d});
            m_ptr = m_ptr + 32'd4;
            exp_cnt++;
        end
        wait_idle("instr");
    endtask

    task automatic chk_cnt(input string name);
        chk(name, {16'b0, O_word_cnt}, 32'(exp_cnt) & 32'h0000_FFFF);
    endtask

    // Monitor: observes the bus just before each rising edge and checks writes against the scoreboard.
    always begin
        wr_t e;
        @(negedge usb_clk);
        #2;
        if (!reset_i) begin
            if (!O_reset_instr_valid) clr_i_seen++;
            if (!O_reset_new_addr_valid) clr_a_seen++;
            if (obi_req_o) begin
                req_cyc++;
                chk("we", {31'b0, obi_we_o}, 32'd1);
                chk("be", {28'b0, obi_be_o}, 32'hF);
                if (obi_gnt_i) begin
                    wr_seen++;
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: got addr %h data %h expected none", obi_addr_o, obi_wdata_o);
                    end else begin
                        e = sb.pop_front();
                        chk("wr_addr", obi_addr_o, e.addr);
                        chk("wr_data", obi_wdata_o, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, c0, w0, k;
        logic [31:0] d;

        // Reset values.
        repeat (3) tick();
        reset_i = 1'b0;
        tick();
        chk("rst_req", {31'b0, obi_req_o}, 32'd0);
        chk("rst_addr", obi_addr_o, 32'd0);
        chk("rst_wdata", obi_wdata_o, 32'd0);
        chk("rst_clr", {30'b0, O_reset_new_addr_valid, O_reset_instr_valid}, 32'd3);
        chk("rst_busy", {31'b0, O_busy}, 32'd0);
        chk("rst_err", {31'b0, O_error}, 32'd0);
        chk_cnt("rst_cnt");

        // Unaligned address then one instruction; grant after two cycles, rvalid one cycle later.
        prog_en   = 1'b1;
        gnt_delay = 2;
        rsp_delay = 0;
        c0        = clr_a_seen;
        post_addr(32'h0000_1002);
        chk("addr_clr_pulses", 32'(clr_a_seen - c0), 32'd1);
        c0            = clr_i_seen;
        I_instruction = 32'hDEAD_BEEF;
        st_instr      = 1'b1;
        sb.push_back('{32'h0000_1000, 32'hDEAD_BEEF});
        m_ptr = 32'h0000_1004;
        exp_cnt++;
        tick();
        chk("req_before_sample", {31'b0, obi_req_o}, 32'd0);
        tick();
        chk("req_latency", {31'b0, obi_req_o}, 32'd1);
        wait_idle("first");
        chk("instr_clr_pulses", 32'(clr_i_seen - c0), 32'd1);
        chk_cnt("cnt_first");

        // Auto-increment.
        post_addr(32'h0000_2000);
        for (int i = 0; i < 3; i++) post_instr($urandom, 1'b1);
        chk_cnt("cnt_autoinc");

        // Pointer wrap at the top of the address space.
        post_addr(32'hFFFF_FFFE);
        post_instr(32'h1111_2222, 1'b1);
        post_instr(32'h3333_4444, 1'b1);
        chk_cnt("cnt_wrap");

        // Both flags in the same cycle: address first.
        I_address     = 32'h0000_3000;
        I_instruction = 32'hCAFE_F00D;
        st_addr       = 1'b1;
        st_instr      = 1'b1;
        m_ptr         = 32'h0000_3000;
        sb.push_back('{m_ptr, 32'hCAFE_F00D});
        m_ptr = m_ptr + 32'd4;
        exp_cnt++;
        wait_idle("both");
        chk_cnt("cnt_both");

        // Instruction flag held high after the clear pulse.
        hold_cycles = 10;
        w0          = wr_seen;
        post_instr(32'h5555_AAAA, 1'b1);
        hold_cycles = 0;
        chk("held_flag_writes", 32'(wr_seen - w0), 32'd1);

        // prog_en gating.
        prog_en  = 1'b0;
        st_instr = 1'b1;
        r0       = req_cyc;
        c0       = clr_i_seen;
        repeat (20) tick();
        chk("gate_req", 32'(req_cyc - r0), 32'd0);
        chk("gate_clr", 32'(clr_i_seen - c0), 32'd0);
        chk("gate_busy", {31'b0, O_busy}, 32'd0);
        st_instr = 1'b0;
        tick();
        prog_en = 1'b1;

        // Grant timeout: word dropped, error sticky, pointer unchanged.
        gnt_en = 1'b0;
        r0     = req_cyc;
        c0     = clr_i_seen;
        post_instr(32'hBAD0_BAD0, 1'b0);
        gnt_en = 1'b1;
        chk("timeout_req_cycles", 32'(req_cyc - r0), 32'd4);
        chk("timeout_err", {31'b0, O_error}, 32'd1);
        chk("timeout_clr", 32'(clr_i_seen - c0), 32'd1);
        chk_cnt("timeout_cnt");
        post_instr(32'h0BAD_C0DE, 1'b1);
        chk("err_sticky", {31'b0, O_error}, 32'd1);

        // Randomized mix.
        for (int i = 0; i < 30; i++) begin
            gnt_delay = $urandom_range(0, 2);
            rsp_delay = $urandom_range(0, 3);
            k         = $urandom_range(0, 9);
            d         = $urandom;
            if (k < 2) begin
                post_addr($urandom);
            end else if (k == 2) begin
                I_address     = $urandom;
                I_instruction = d;
                st_addr       = 1'b1;
                st_instr      = 1'b1;
                m_ptr         = I_address & 32'hFFFF_FFFC;
                sb.push_back('{m_ptr, d});
                m_ptr = m_ptr + 32'd4;
                exp_cnt++;
                wait_idle("rand_both");
            end else begin
                post_instr(d, 1'b1);
            end
            chk_cnt("rand_cnt");
        end

        // Reset while waiting for the response; the late rvalid must be ignored.
        gnt_delay     = 0;
        rsp_delay     = 3;
        I_instruction = 32'h7777_8888;
        st_instr      = 1'b1;
        sb.push_back('{m_ptr, 32'h7777_8888});
        for (k = 0; k < 20; k++) begin
            tick();
            if (hs) break;
        end
        chk("midrst_grant_seen", 32'(k < 20), 32'd1);
        tick();
        chk("midrst_busy_before", {31'b0, O_busy}, 32'd1);
        reset_i  = 1'b1;
        st_instr = 1'b0;
        tick();
        chk("midrst_req", {31'b0, obi_req_o}, 32'd0);
        chk("midrst_addr", obi_addr_o, 32'd0);
        chk("midrst_wdata", obi_wdata_o, 32'd0);
        chk("midrst_busy", {31'b0, O_busy}, 32'd0);
        chk("midrst_err", {31'b0, O_error}, 32'd0);
        chk("midrst_clr", {30'b0, O_reset_new_addr_valid, O_reset_instr_valid}, 32'd3);
        reset_i = 1'b0;
        exp_cnt = 0;
        m_ptr   = '0;
        repeat (6) tick();
        chk_cnt("midrst_late_rvalid_cnt");
        chk("midrst_idle", {31'b0, O_busy}, 32'd0);

        // Still functional after reset.
        rsp_delay = 0;
        post_instr(32'h9999_0000, 1'b1);
        chk_cnt("post_rst_cnt");

        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
